// File: rtl/program_sequencer.sv
// Instruction-address sequencer with a RUN/HALT/ERR control FSM and a small
// return-address stack for call/ret; every output comes straight from a flop.
module program_sequencer #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           complete,
  input  logic                           w_en,
  input  logic                           inc,
  input  logic                           call,
  input  logic                           ret,
  input  logic [DATA_W-1:0]              data_in,
  output logic [ADDR_W-1:0]              instruction_address,
  output logic                           running,
  output logic                           halted,
  output logic                           stack_err,
  output logic [$clog2(STACK_DEPTH):0]   depth
);

  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, HALT, ERR} state_t;
  typedef enum logic [2:0] {ACT_HOLD, ACT_LOAD, ACT_PUSH, ACT_POP, ACT_INC, ACT_CLEAR} action_t;

  state_t  state, next_state;
  action_t action;

  logic              en_q;
  logic              armed;
  logic              start;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] addr_plus1;
  logic [PTR_W-1:0]  push_ptr;
  logic [PTR_W-1:0]  pop_ptr;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic              running_d, halted_d, stack_err_d;
  logic              unused_data;

  // armed stays low after reset until en is seen low, so an en already high
  // at reset release cannot masquerade as a fresh rising edge.
  assign start      = en & ~en_q & armed;
  assign target     = data_in[ADDR_W-1:0];
  assign addr_plus1 = instruction_address + ADDR_W'(1);
  assign full       = (depth == DEPTH_W'(STACK_DEPTH));
  assign empty      = (depth == '0);
  assign push_ptr   = depth[PTR_W-1:0];
  assign pop_ptr    = depth[PTR_W-1:0] - PTR_W'(1);
  assign unused_data = ^data_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      en_q <= en;
      if (!en) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    action     = ACT_HOLD;
    case (state)
      IDLE: begin
        if (start) next_state = RUN;
      end
      RUN: begin
        if (complete)  next_state = HALT;
        else if (w_en) action = ACT_LOAD;
        else if (call) begin
          if (full) next_state = ERR;
          else      action = ACT_PUSH;
        end else if (ret) begin
          if (empty) next_state = ERR;
          else       action = ACT_POP;
        end else if (inc) action = ACT_INC;
      end
      HALT, ERR: begin
        if (start) begin
          next_state = RUN;
          action     = ACT_CLEAR;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    running_d   = (next_state == RUN);
    halted_d    = (next_state == HALT);
    stack_err_d = (next_state == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running   <= 1'b0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      running   <= running_d;
      halted    <= halted_d;
      stack_err <= stack_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction_address <= '0;
      depth               <= '0;
    end else begin
      case (action)
        ACT_LOAD: instruction_address <= target;
        ACT_PUSH: begin
          instruction_address <= target;
          depth               <= depth + DEPTH_W'(1);
        end
        ACT_POP: begin
          instruction_address <= stack_mem[pop_ptr];
          depth               <= depth - DEPTH_W'(1);
        end
        ACT_INC: instruction_address <= addr_plus1;
        ACT_CLEAR: begin
          instruction_address <= '0;
          depth               <= '0;
        end
        default: ;
      endcase
    end
  end

  // Entries above depth are dead, so the storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (action == ACT_PUSH) stack_mem[push_ptr] <= addr_plus1;
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench: directed scenarios plus random stimulus, all checked
// against a queue-based behavioural model of the sequencer.
module tb_program_sequencer;

  localparam int ADDR_W      = 6;
  localparam int DATA_W      = 32;
  localparam int STACK_DEPTH = 4;
  localparam int ADDR_MOD    = 1 << ADDR_W;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam int M_ERR  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0, complete = 1'b0, w_en = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [ADDR_W-1:0] instruction_address;
  logic              running, halted, stack_err;
  logic [2:0]        depth;

  int errors = 0;
  int checks = 0;

  int m_state;
  int m_addr;
  int m_stack[$];
  bit m_en_prev;
  bit m_seen_low;

  program_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .complete(complete), .w_en(w_en),
    .inc(inc), .call(call), .ret(ret), .data_in(data_in),
    .instruction_address(instruction_address), .running(running),
    .halted(halted), .stack_err(stack_err), .depth(depth)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_state    = M_IDLE;
    m_addr     = 0;
    m_stack.delete();
    m_en_prev  = 1'b0;
    m_seen_low = 1'b0;
  endtask

  // One clock edge of the architectural behaviour, from the current inputs.
  task automatic modelStep();
    bit is_start;
    is_start = en && !m_en_prev && m_seen_low;
    case (m_state)
      M_IDLE: if (is_start) m_state = M_RUN;
      M_RUN: begin
        if (complete) m_state = M_HALT;
        else if (w_en) m_addr = int'(data_in) & (ADDR_MOD - 1);
        else if (call) begin
          if (m_stack.size() >= STACK_DEPTH) m_state = M_ERR;
          else begin
            m_stack.push_back((m_addr + 1) % ADDR_MOD);
            m_addr = int'(data_in) & (ADDR_MOD - 1);
          end
        end else if (ret) begin
          if (m_stack.size() == 0) m_state = M_ERR;
          else m_addr = m_stack.pop_back();
        end else if (inc) m_addr = (m_addr + 1) % ADDR_MOD;
      end
      default: begin
        if (is_start) begin
          m_state = M_RUN;
          m_addr  = 0;
          m_stack.delete();
        end
      end
    endcase
    m_en_prev = en;
    if (!en) m_seen_low = 1'b1;
  endtask

  task automatic compareAll();
    checkOutput("addr",      32'(instruction_address), 32'(m_addr));
    checkOutput("running",   32'(running),   32'(m_state == M_RUN));
    checkOutput("halted",    32'(halted),    32'(m_state == M_HALT));
    checkOutput("stack_err", 32'(stack_err), 32'(m_state == M_ERR));
    checkOutput("depth",     32'(depth),     32'(m_stack.size()));
  endtask

  task automatic applyStimulus(input bit e, input bit c, input bit w, input bit i,
                               input bit ca, input bit r, input logic [31:0] d);
    @(negedge clk);
    en = e; complete = c; w_en = w; inc = i; call = ca; ret = r; data_in = d;
    @(posedge clk);
    modelStep();
    #1 compareAll();
  endtask

  task automatic doReset(input bit e);
    @(negedge clk);
    en = e; complete = 0; w_en = 0; inc = 0; call = 0; ret = 0; data_in = '0;
    rst = 1'b1;
    modelReset();
    #1 compareAll();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    modelReset();
    doReset(1'b0);
    checkOutput("rst_addr", 32'(instruction_address), 32'd0);

    // Start pulse then three increments.
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("start_running", 32'(running), 32'd1);
    checkOutput("start_addr", 32'(instruction_address), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("inc_addr", 32'(instruction_address), 32'(k));
    end

    // Call from 5 to 0x20, then return to 6.
    applyStimulus(0, 0, 1, 0, 0, 0, 32'd5);
    checkOutput("jump_addr", 32'(instruction_address), 32'd5);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h20);
    checkOutput("call_addr", 32'(instruction_address), 32'h20);
    checkOutput("call_depth", 32'(depth), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("ret_addr", 32'(instruction_address), 32'd6);
    checkOutput("ret_depth", 32'(depth), 32'd0);

    // Upper data bits ignored; wrap from 63 to 0 is not an error.
    applyStimulus(0, 0, 1, 0, 0, 0, 32'hABCD_EF7F);
    checkOutput("jump_mask", 32'(instruction_address), 32'd63);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("wrap_addr", 32'(instruction_address), 32'd0);
    checkOutput("wrap_err", 32'(stack_err), 32'd0);

    // Underflow, then restart from ERR.
    applyStimulus(0, 0, 1, 0, 0, 0, 32'd12);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("uflow_err", 32'(stack_err), 32'd1);
    checkOutput("uflow_addr", 32'(instruction_address), 32'd12);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("restart_run", 32'(running), 32'd1);
    checkOutput("restart_addr", 32'(instruction_address), 32'd0);

    // complete wins over w_en and inc; HALT then ignores inc.
    applyStimulus(0, 0, 1, 0, 0, 0, 32'd9);
    applyStimulus(0, 1, 1, 1, 0, 0, 32'd3);
    checkOutput("halt_flag", 32'(halted), 32'd1);
    checkOutput("halt_addr", 32'(instruction_address), 32'd9);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("halt_hold", 32'(instruction_address), 32'd9);

    // Held en gives a single start only.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    checkOutput("held_en_halt", 32'(halted), 32'd1);

    // Stack overflow on the fifth call.
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) applyStimulus(0, 0, 0, 0, 1, 0, 32'(10 * k));
    checkOutput("full_depth", 32'(depth), 32'd4);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'd50);
    checkOutput("oflow_err", 32'(stack_err), 32'd1);
    checkOutput("oflow_addr", 32'(instruction_address), 32'd40);

    // Reset mid-run with en high: no start until en falls and rises again.
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'd7);
    doReset(1'b1);
    checkOutput("mid_rst_depth", 32'(depth), 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("no_false_start", 32'(running), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("rearm_start", 32'(running), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("stack_discarded", 32'(stack_err), 32'd1);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) doReset(1'(($urandom_range(0, 1))));
      applyStimulus($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4,
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 50,
                    $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
                    $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 6, instruction address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, width of data_in.
REQ-003 The module SHALL have parameter STACK_DEPTH, default 4, return-address stack entries (power of 2, >=2).
REQ-004 The module SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-006 The module SHALL have port en, input, 1, start request; rising edge detected synchronously.
REQ-007 The module SHALL have port complete, input, 1, halt request.
REQ-008 The module SHALL have port w_en, input, 1, jump; loads data_in[ADDR_W-1:0].
REQ-009 The module SHALL have port inc, input, 1, advance address by 1.
REQ-010 The module SHALL have port call, input, 1, push return address and jump to data_in[ADDR_W-1:0].
REQ-011 The module SHALL have port ret, input, 1, pop return address into the address register.
REQ-012 The module SHALL have port data_in, input, DATA_W, jump/call target source.
REQ-013 The module SHALL have port instruction_address, output, ADDR_W, registered current address.
REQ-014 The module SHALL have port running, output, 1, high in RUN state.
REQ-015 The module SHALL have port halted, output, 1, high in HALT state.
REQ-016 The module SHALL have port stack_err, output, 1, high in ERR state.
REQ-017 The module SHALL have port depth, output, $clog2(STACK_DEPTH)+1, current stack occupancy.

Function
REQ-018 The module SHALL implement states IDLE, RUN, HALT, ERR, all outputs registered.
REQ-019 The module SHALL detect a start as en=1 while the en value registered in the previous cycle was 0.
REQ-020 In IDLE, a start SHALL move to RUN next cycle with address held; no other input acts in IDLE.
REQ-021 In RUN, the module SHALL apply one action per cycle with priority complete > w_en > call > ret > inc > hold.
REQ-022 complete in RUN SHALL move to HALT and freeze address and stack.
REQ-023 w_en SHALL load data_in[ADDR_W-1:0] next cycle; upper data_in bits SHALL be ignored.
REQ-024 call with depth<STACK_DEPTH SHALL push (address+1) mod 2^ADDR_W, load the target, and increment depth.
REQ-025 ret with depth>0 SHALL load the top entry and decrement depth.
REQ-026 call with depth==STACK_DEPTH (overflow) or ret with depth==0 (underflow) SHALL move to ERR with address and stack unchanged.
REQ-027 inc SHALL add 1 modulo 2^ADDR_W; all-ones SHALL wrap to 0 without error.
REQ-028 In HALT or ERR, inputs other than start SHALL be ignored.
REQ-029 A start in HALT or ERR SHALL clear address to 0, clear depth to 0, and enter RUN.
REQ-030 Holding en high SHALL NOT generate repeated starts.

Reset
REQ-031 rst=1 SHALL immediately force address 0, depth 0, state IDLE, running/halted/stack_err 0, and clear the registered en to 0.
REQ-032 Reset mid-operation SHALL discard stack contents; after release, en already high SHALL NOT count as a start until it falls and rises.

Verification
REQ-033 The bench SHALL check: reset, en pulse, then inc for 3 cycles -> running=1, address 0,1,2,3.
REQ-034 The bench SHALL check: in RUN at address 5, call with data_in=0x20, then ret -> address 0x20, depth 1, then address 6, depth 0.
REQ-035 The bench SHALL check: at address 63 (ADDR_W=6), inc -> address 0, stack_err=0.
REQ-036 The bench SHALL check: ret with depth 0 -> stack_err=1, address unchanged; a new en edge -> RUN, address 0.
REQ-037 The bench SHALL check: complete, w_en, and inc all high at address 9 -> HALT, address 9; further inc -> address stays 9.
REQ-038 The bench SHALL check: STACK_DEPTH=4 with 5 successive calls -> depth 4 after the fourth call, ERR after the fifth, address equal to the fourth call's target.
